// File: rtl/hv_efuse_load_ctrl_if.sv
// Efuse load bundle: efuse macro read port, register write port and the load handshake.
interface hv_efuse_load_ctrl_if #(
   parameter int EFUSE_WORD_NUM = 8,
   parameter int EFUSE_DATA_W   = 8
);
   localparam int AW = $clog2(EFUSE_WORD_NUM);

   logic                    i_efuse_load_req;
   logic                    i_efuse_ctrl_reg_en;
   logic                    o_efuse_load_done;
   logic [AW-1:0]           o_efuse_addr;
   logic                    o_efuse_rd_en;
   logic [EFUSE_DATA_W-1:0] i_efuse_rdata;
   logic                    o_reg_wr_en;
   logic [AW-1:0]           o_reg_wr_addr;
   logic [EFUSE_DATA_W-1:0] o_reg_wr_data;
   logic                    o_reg_efuse_vld;

   modport slave (
      input  i_efuse_load_req,
      input  i_efuse_ctrl_reg_en,
      input  i_efuse_rdata,
      output o_efuse_load_done,
      output o_efuse_addr,
      output o_efuse_rd_en,
      output o_reg_wr_en,
      output o_reg_wr_addr,
      output o_reg_wr_data,
      output o_reg_efuse_vld
   );

   modport master (
      output i_efuse_load_req,
      output i_efuse_ctrl_reg_en,
      output i_efuse_rdata,
      input  o_efuse_load_done,
      input  o_efuse_addr,
      input  o_efuse_rd_en,
      input  o_reg_wr_en,
      input  o_reg_wr_addr,
      input  o_reg_wr_data,
      input  o_reg_efuse_vld
   );
endinterface

// File: rtl/hv_efuse_load_ctrl.sv
// Efuse-to-register loader; HV_EFUSE_CHKSUM_EN gates vld on an XOR checksum of the image.
// Latency: EFUSE_WORD_NUM*(EFUSE_RD_PULSE_NUM+2) cycles from request to done.
// Backpressure: none; dropping request or enable aborts, a held request never retriggers.
module hv_efuse_load_ctrl #(
   parameter int EFUSE_WORD_NUM     = 8,
   parameter int EFUSE_DATA_W       = 8,
   parameter int EFUSE_RD_PULSE_NUM = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   hv_efuse_load_ctrl_if.slave  efuse_if
);
   localparam int AW = $clog2(EFUSE_WORD_NUM);
   localparam int PW = 4;
   localparam logic [AW-1:0] LAST_IDX   = AW'(EFUSE_WORD_NUM - 1);
   localparam logic [PW-1:0] LAST_PULSE = PW'(EFUSE_RD_PULSE_NUM - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_CAPTURE,
      ST_DONE
   } state_t;

   state_t                  state_q, state_d;
   logic [AW-1:0]           idx_q, idx_d;
   logic [PW-1:0]           pcnt_q, pcnt_d;
   logic [EFUSE_DATA_W-1:0] rdata_q, rdata_d;
   logic                    vld_q, vld_d;
   logic                    armed_q, armed_d;
   logic                    go;
`ifdef HV_EFUSE_CHKSUM_EN
   logic [EFUSE_DATA_W-1:0] acc_q, acc_d;
`endif

   assign go = efuse_if.i_efuse_load_req & efuse_if.i_efuse_ctrl_reg_en;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         pcnt_q  <= '0;
         rdata_q <= '0;
         vld_q   <= 1'b0;
         armed_q <= 1'b1;
`ifdef HV_EFUSE_CHKSUM_EN
         acc_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         pcnt_q  <= pcnt_d;
         rdata_q <= rdata_d;
         vld_q   <= vld_d;
         armed_q <= armed_d;
`ifdef HV_EFUSE_CHKSUM_EN
         acc_q   <= acc_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      pcnt_d  = pcnt_q;
      rdata_d = rdata_q;
      vld_d   = vld_q;
      armed_d = armed_q;
`ifdef HV_EFUSE_CHKSUM_EN
      acc_d   = acc_q;
`endif
      // A load may only start after the request has been seen low since the last start.
      if (!efuse_if.i_efuse_load_req) begin
         armed_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (go && armed_q) begin
               state_d = ST_SETUP;
               idx_d   = '0;
               vld_d   = 1'b0;
               armed_d = 1'b0;
`ifdef HV_EFUSE_CHKSUM_EN
               acc_d   = '0;
`endif
            end
         end
         ST_SETUP: begin
            if (!go) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_STROBE;
               pcnt_d  = '0;
            end
         end
         ST_STROBE: begin
            if (!go) begin
               state_d = ST_IDLE;
            end else if (pcnt_q == LAST_PULSE) begin
               state_d = ST_CAPTURE;
               rdata_d = efuse_if.i_efuse_rdata;
            end else begin
               pcnt_d = pcnt_q + 1'b1;
            end
         end
         ST_CAPTURE: begin
`ifdef HV_EFUSE_CHKSUM_EN
            if (idx_q != LAST_IDX) begin
               acc_d = acc_q ^ rdata_q;
            end
`endif
            if (!go) begin
               state_d = ST_IDLE;
            end else if (idx_q == LAST_IDX) begin
               state_d = ST_DONE;
`ifdef HV_EFUSE_CHKSUM_EN
               vld_d   = (acc_q == rdata_q);
`else
               vld_d   = 1'b1;
`endif
            end else begin
               state_d = ST_SETUP;
               idx_d   = idx_q + 1'b1;
            end
         end
         ST_DONE: begin
            if (!efuse_if.i_efuse_load_req) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs decode from the current state so reset clears them asynchronously.
   assign efuse_if.o_efuse_rd_en     = (state_q == ST_STROBE);
   assign efuse_if.o_efuse_addr      = ((state_q == ST_SETUP) || (state_q == ST_STROBE)) ? idx_q : '0;
   assign efuse_if.o_reg_wr_en       = (state_q == ST_CAPTURE);
   assign efuse_if.o_reg_wr_addr     = (state_q == ST_CAPTURE) ? idx_q : '0;
   assign efuse_if.o_reg_wr_data     = (state_q == ST_CAPTURE) ? rdata_q : '0;
   assign efuse_if.o_efuse_load_done = (state_q == ST_DONE);
   assign efuse_if.o_reg_efuse_vld   = vld_q;

endmodule

// File: tb/tb_hv_efuse_load_ctrl.sv
// Directed bench for hv_efuse_load_ctrl with a behavioural efuse macro and write logger.
module tb_hv_efuse_load_ctrl;
   localparam int WN       = 8;
   localparam int DW       = 8;
   localparam int PN       = 4;
   localparam int LOAD_CYC = WN * (PN + 2);

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   hv_efuse_load_ctrl_if #(.EFUSE_WORD_NUM(WN), .EFUSE_DATA_W(DW)) efuse_if ();

   hv_efuse_load_ctrl #(
      .EFUSE_WORD_NUM    (WN),
      .EFUSE_DATA_W      (DW),
      .EFUSE_RD_PULSE_NUM(PN)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .efuse_if(efuse_if)
   );

   logic [DW-1:0] mem [WN];
   always_comb efuse_if.i_efuse_rdata = mem[efuse_if.o_efuse_addr];

   int          wr_cnt   = 0;
   int          rd_cyc   = 0;
   int          done_cyc = 0;
   logic [2:0]  wr_addr_log [64];
   logic [7:0]  wr_data_log [64];

   always @(negedge clk) begin
      if (efuse_if.o_reg_wr_en) begin
         wr_addr_log[wr_cnt % 64] <= efuse_if.o_reg_wr_addr;
         wr_data_log[wr_cnt % 64] <= efuse_if.o_reg_wr_data;
         wr_cnt <= wr_cnt + 1;
      end
      if (efuse_if.o_efuse_rd_en)     rd_cyc   <= rd_cyc + 1;
      if (efuse_if.o_efuse_load_done) done_cyc <= done_cyc + 1;
   end

   int checks = 0;
   int errors = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Called just after the start edge; returns edges until done is seen (0 on timeout).
   task automatic wait_done(output int n);
      n = 0;
      for (int k = 1; k <= 200; k++) begin
         @(posedge clk); #1;
         if (efuse_if.o_efuse_load_done) begin
            n = k;
            break;
         end
      end
   endtask

   task automatic check_writes(input string tag, input int base, input int num);
      check_val({tag, "_wr_cnt"}, 32'(wr_cnt - base), 32'(num));
      for (int i = 0; i < num; i++) begin
         check_val({tag, "_wr_addr"}, 32'(wr_addr_log[(base + i) % 64]), 32'(i));
         check_val({tag, "_wr_data"}, 32'(wr_data_log[(base + i) % 64]), 32'(mem[i]));
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_rd_en"}, 32'(efuse_if.o_efuse_rd_en), 0);
      check_val({tag, "_addr"},  32'(efuse_if.o_efuse_addr), 0);
      check_val({tag, "_wr_en"}, 32'(efuse_if.o_reg_wr_en), 0);
      check_val({tag, "_wr_ad"}, 32'(efuse_if.o_reg_wr_addr), 0);
      check_val({tag, "_wr_dt"}, 32'(efuse_if.o_reg_wr_data), 0);
      check_val({tag, "_done"},  32'(efuse_if.o_efuse_load_done), 0);
      check_val({tag, "_vld"},   32'(efuse_if.o_reg_efuse_vld), 0);
   endtask

   int n;
   int base;
   int rbase;
   int dbase;
   logic exp_bad_vld;

   initial begin
      efuse_if.i_efuse_load_req    = 1'b0;
      efuse_if.i_efuse_ctrl_reg_en = 1'b1;
      for (int i = 0; i < WN - 1; i++) mem[i] = 8'(i + 1);
      mem[WN-1] = 8'h00;
`ifdef HV_EFUSE_CHKSUM_EN
      exp_bad_vld = 1'b0;
`else
      exp_bad_vld = 1'b1;
`endif

      // Reset state
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Good image, request held high
      base  = wr_cnt;
      rbase = rd_cyc;
      efuse_if.i_efuse_load_req = 1'b1;
      @(posedge clk); #1;
      check_val("setup_rd_en", 32'(efuse_if.o_efuse_rd_en), 0);
      check_val("setup_addr",  32'(efuse_if.o_efuse_addr), 0);
      wait_done(n);
      check_val("load_cyc", 32'(n), 32'(LOAD_CYC));
      check_val("load_vld", 32'(efuse_if.o_reg_efuse_vld), 1);
      check_writes("load", base, WN);
      check_val("load_strobe_cyc", 32'(rd_cyc - rbase), 32'(WN * PN));

      // Held request does not retrigger
      base = wr_cnt;
      repeat (20) @(posedge clk);
      #1;
      check_val("hold_done", 32'(efuse_if.o_efuse_load_done), 1);
      check_val("hold_no_wr", 32'(wr_cnt - base), 0);

      // Request low for one cycle, then a second full load
      @(negedge clk);
      efuse_if.i_efuse_load_req = 1'b0;
      @(posedge clk); #1;
      check_val("drop_done", 32'(efuse_if.o_efuse_load_done), 0);
      @(negedge clk);
      efuse_if.i_efuse_load_req = 1'b1;
      @(posedge clk); #1;
      check_val("reload_vld_clr", 32'(efuse_if.o_reg_efuse_vld), 0);
      wait_done(n);
      check_val("reload_cyc", 32'(n), 32'(LOAD_CYC));
      check_val("reload_vld", 32'(efuse_if.o_reg_efuse_vld), 1);

      // Bad checksum word
      @(negedge clk);
      efuse_if.i_efuse_load_req = 1'b0;
      mem[WN-1] = 8'h5A;
      @(negedge clk);
      base = wr_cnt;
      efuse_if.i_efuse_load_req = 1'b1;
      @(posedge clk);
      wait_done(n);
      check_val("chk_cyc", 32'(n), 32'(LOAD_CYC));
      check_val("chk_done", 32'(efuse_if.o_efuse_load_done), 1);
      check_val("chk_vld", 32'(efuse_if.o_reg_efuse_vld), 32'(exp_bad_vld));
      check_val("chk_last_wr", 32'(wr_data_log[(base + WN - 1) % 64]), 32'h5A);

      // Abort in the STROBE of word 3
      @(negedge clk);
      efuse_if.i_efuse_load_req = 1'b0;
      mem[WN-1] = 8'h00;
      @(negedge clk);
      base  = wr_cnt;
      dbase = done_cyc;
      efuse_if.i_efuse_load_req = 1'b1;
      @(posedge clk);
      repeat (20) @(posedge clk);
      #1;
      check_val("abort_pre_rd_en", 32'(efuse_if.o_efuse_rd_en), 1);
      check_val("abort_pre_addr",  32'(efuse_if.o_efuse_addr), 3);
      efuse_if.i_efuse_load_req = 1'b0;
      @(posedge clk); #1;
      check_all_zero("abort");
      repeat (30) @(negedge clk);
      #1;
      check_writes("abort", base, 3);
      check_val("abort_no_done", 32'(done_cyc - dbase), 0);

      // Reset during word 5, restart after release with request high
      @(negedge clk);
      efuse_if.i_efuse_load_req = 1'b1;
      @(posedge clk);
      repeat (32) @(posedge clk);
      #1;
      check_val("rst_pre_addr",  32'(efuse_if.o_efuse_addr), 5);
      check_val("rst_pre_rd_en", 32'(efuse_if.o_efuse_rd_en), 1);
      rst_n = 1'b0;
      #1;
      check_all_zero("rst_mid");
      repeat (3) @(negedge clk);
      base = wr_cnt;
      rst_n = 1'b1;
      @(posedge clk);
      wait_done(n);
      check_val("rst_restart_cyc", 32'(n), 32'(LOAD_CYC));
      check_writes("rst_restart", base, WN);
      check_val("rst_restart_vld", 32'(efuse_if.o_reg_efuse_vld), 1);

      // Enable low: request ignored
      @(negedge clk);
      efuse_if.i_efuse_load_req    = 1'b0;
      efuse_if.i_efuse_ctrl_reg_en = 1'b0;
      @(negedge clk);
      base  = wr_cnt;
      rbase = rd_cyc;
      dbase = done_cyc;
      efuse_if.i_efuse_load_req = 1'b1;
      repeat (100) @(negedge clk);
      #1;
      check_val("en_off_rd",   32'(rd_cyc - rbase), 0);
      check_val("en_off_wr",   32'(wr_cnt - base), 0);
      check_val("en_off_done", 32'(done_cyc - dbase), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
